// File: rtl/rx_phase_ctrl.sv
// rx_phase_ctrl: sample-enable generation and oversampling-phase sweep for the
// receiver matched filter; locks the phase select to the phase with fewest errors.
module rx_phase_ctrl #(
   parameter int  OS       = 4,
   parameter int  CLK_DIV  = 4,
   parameter int  SETTLE   = 24,
   parameter int  WINDOW   = 1024,
   parameter int  CNT_BITS = 16,
   localparam int PW       = $clog2(OS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic                i_detection,
   input  logic                i_ref_bit,
   output logic                o_enable,
   output logic [PW-1:0]       o_phase,
   output logic                o_sym_strobe,
   output logic                o_busy,
   output logic                o_locked,
   output logic [CNT_BITS-1:0] o_best_err
);
   localparam int DW   = $clog2(CLK_DIV);
   localparam int SMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
   localparam int SW   = $clog2(SMAX + 1);
   localparam logic [DW-1:0]       DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [PW-1:0]       PH_LAST  = PW'(OS - 1);
   localparam logic [SW-1:0]       SET_LAST = SW'(SETTLE - 1);
   localparam logic [SW-1:0]       WIN_LAST = SW'(WINDOW - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_MEASURE = 3'd2,
      ST_EVAL    = 3'd3,
      ST_LOCK    = 3'd4
   } state_t;

   state_t              state_r, state_s;
   logic [DW-1:0]       div_cnt_r;
   logic [PW-1:0]       samp_cnt_r;
   logic [SW-1:0]       sym_cnt_r, sym_cnt_s;
   logic [CNT_BITS-1:0] err_cnt_r, err_cnt_s;
   logic [CNT_BITS-1:0] best_err_s;
   logic [PW-1:0]       best_phase_r, best_phase_s;
   logic [PW-1:0]       phase_s;
   logic                better_s, busy_s, locked_s;

   // Free-running divider, sample counter and the enable/strobe pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_r    <= {DW{1'b0}};
         samp_cnt_r   <= {PW{1'b0}};
         o_enable     <= 1'b0;
         o_sym_strobe <= 1'b0;
      end else begin
         if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= {DW{1'b0}};
         end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
         end
         if (o_enable) begin
            samp_cnt_r <= (samp_cnt_r == PH_LAST) ? {PW{1'b0}} : samp_cnt_r + PW'(1);
         end else begin
            samp_cnt_r <= samp_cnt_r;
         end
         o_enable     <= (div_cnt_r == DIV_LAST);
         o_sym_strobe <= o_enable && (samp_cnt_r == o_phase);
      end
   end

   // Sweep sequencing: next state, counters and best-phase bookkeeping
   always_comb begin
      state_s      = state_r;
      phase_s      = o_phase;
      sym_cnt_s    = sym_cnt_r;
      err_cnt_s    = err_cnt_r;
      best_err_s   = o_best_err;
      best_phase_s = best_phase_r;
      better_s     = (err_cnt_r < o_best_err);
      case (state_r)
         ST_IDLE, ST_LOCK: begin
            if (i_start) begin
               state_s      = ST_SETTLE;
               phase_s      = {PW{1'b0}};
               best_err_s   = CNT_MAX;
               best_phase_s = {PW{1'b0}};
               sym_cnt_s    = {SW{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         ST_SETTLE: begin
            if (o_sym_strobe && (sym_cnt_r == SET_LAST)) begin
               sym_cnt_s = {SW{1'b0}};
               err_cnt_s = {CNT_BITS{1'b0}};
               state_s   = ST_MEASURE;
            end else if (o_sym_strobe) begin
               sym_cnt_s = sym_cnt_r + SW'(1);
            end else begin
               sym_cnt_s = sym_cnt_r;
            end
         end
         ST_MEASURE: begin
            if (o_sym_strobe) begin
               // Error count saturates instead of wrapping
               if ((i_detection != i_ref_bit) && (err_cnt_r != CNT_MAX)) begin
                  err_cnt_s = err_cnt_r + CNT_BITS'(1);
               end else begin
                  err_cnt_s = err_cnt_r;
               end
               if (sym_cnt_r == WIN_LAST) begin
                  sym_cnt_s = {SW{1'b0}};
                  state_s   = ST_EVAL;
               end else begin
                  sym_cnt_s = sym_cnt_r + SW'(1);
               end
            end else begin
               sym_cnt_s = sym_cnt_r;
            end
         end
         ST_EVAL: begin
            // Strict less-than keeps the earlier (lower) phase on a tie
            if (better_s) begin
               best_err_s   = err_cnt_r;
               best_phase_s = o_phase;
            end else begin
               best_phase_s = best_phase_r;
            end
            if (o_phase == PH_LAST) begin
               state_s = ST_LOCK;
               phase_s = best_phase_s;
            end else begin
               state_s   = ST_SETTLE;
               phase_s   = o_phase + PW'(1);
               sym_cnt_s = {SW{1'b0}};
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      busy_s   = (state_s == ST_SETTLE) || (state_s == ST_MEASURE) || (state_s == ST_EVAL);
      locked_s = (state_s == ST_LOCK);
   end

   // State register and registered sweep outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         sym_cnt_r    <= {SW{1'b0}};
         err_cnt_r    <= {CNT_BITS{1'b0}};
         best_phase_r <= {PW{1'b0}};
         o_phase      <= {PW{1'b0}};
         o_best_err   <= CNT_MAX;
         o_busy       <= 1'b0;
         o_locked     <= 1'b0;
      end else begin
         state_r      <= state_s;
         sym_cnt_r    <= sym_cnt_s;
         err_cnt_r    <= err_cnt_s;
         best_phase_r <= best_phase_s;
         o_phase      <= phase_s;
         o_best_err   <= best_err_s;
         o_busy       <= busy_s;
         o_locked     <= locked_s;
      end
   end
endmodule

// File: tb/tb_rx_phase_ctrl.sv
// Testbench for rx_phase_ctrl: random error injection per phase, checked every
// cycle against a sweep-level reference model, plus literal pinned expectations.
module tb_rx_phase_ctrl;
   localparam int OS       = 4;
   localparam int CLK_DIV  = 4;
   localparam int SETTLE   = 4;
   localparam int WINDOW   = 32;
   localparam int CNT_BITS = 4;
   localparam int PW       = 2;
   localparam int CMAX     = (1 << CNT_BITS) - 1;
   localparam int BOUND    = 4000;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                i_start = 1'b0;
   logic                i_detection = 1'b0;
   logic                i_ref_bit = 1'b0;
   logic                o_enable;
   logic [PW-1:0]       o_phase;
   logic                o_sym_strobe;
   logic                o_busy;
   logic                o_locked;
   logic [CNT_BITS-1:0] o_best_err;

   int n_checks = 0;
   int n_errors = 0;
   int rate[OS];

   // reference model state
   int m_cyc, m_phase, m_best, m_bp, m_nstr, m_errs;
   bit m_en, m_strobe, m_busy, m_locked, m_evalp;

   always #5 clk = ~clk;

   rx_phase_ctrl #(
      .OS(OS), .CLK_DIV(CLK_DIV), .SETTLE(SETTLE), .WINDOW(WINDOW), .CNT_BITS(CNT_BITS)
   ) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_detection(i_detection),
      .i_ref_bit(i_ref_bit), .o_enable(o_enable), .o_phase(o_phase),
      .o_sym_strobe(o_sym_strobe), .o_busy(o_busy), .o_locked(o_locked),
      .o_best_err(o_best_err)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_cyc = 0; m_phase = 0; m_best = CMAX; m_bp = 0; m_nstr = 0; m_errs = 0;
      m_en = 1'b0; m_strobe = 1'b0; m_busy = 1'b0; m_locked = 1'b0; m_evalp = 1'b0;
   endtask

   // One clock of the model: consume the cycle that just ended, then derive the
   // enable/strobe of the new cycle from elapsed time alone.
   task automatic m_step();
      int old_phase;
      old_phase = m_phase;
      if (m_busy) begin
         if (m_evalp) begin
            m_evalp = 1'b0;
            if (m_errs < m_best) begin
               m_best = m_errs;
               m_bp   = m_phase;
            end
            if (m_phase == OS - 1) begin
               m_busy = 1'b0; m_locked = 1'b1; m_phase = m_bp;
            end else begin
               m_phase++; m_nstr = 0; m_errs = 0;
            end
         end else if (m_strobe) begin
            if (m_nstr >= SETTLE && i_detection != i_ref_bit && m_errs < CMAX) m_errs++;
            m_nstr++;
            if (m_nstr == SETTLE + WINDOW) m_evalp = 1'b1;
         end
      end else if (i_start) begin
         m_busy = 1'b1; m_locked = 1'b0; m_phase = 0; m_best = CMAX; m_bp = 0;
         m_nstr = 0; m_errs = 0;
      end
      m_cyc++;
      m_strobe = (m_cyc - 1 > 0) && ((m_cyc - 1) % CLK_DIV == 0) &&
                 (((((m_cyc - 1) / CLK_DIV) - 1) % OS) == old_phase);
      m_en = (m_cyc % CLK_DIV == 0);
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) m_reset();
         else m_step();
      end
   end

   // every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      chk("enable", int'(o_enable), int'(m_en));
      chk("sym_strobe", int'(o_sym_strobe), int'(m_strobe));
      chk("busy", int'(o_busy), int'(m_busy));
      chk("locked", int'(o_locked), int'(m_locked));
      chk("phase", int'(o_phase), m_phase);
      chk("best_err", int'(o_best_err), m_best);
   end

   // data stimulus: per-phase error probability in percent
   initial forever begin
      @(negedge clk);
      i_ref_bit = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < rate[o_phase]) i_detection = ~i_ref_bit;
      else i_detection = i_ref_bit;
   end

   task automatic set_rates(input int r0, input int r1, input int r2, input int r3);
      rate[0] = r0; rate[1] = r1; rate[2] = r2; rate[3] = r3;
   endtask

   task automatic pulse_start();
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
   endtask

   task automatic wait_lock(input string name);
      int t;
      t = 0;
      while (!o_locked && t < BOUND) begin
         @(negedge clk);
         t++;
      end
      #1;
      chk(name, int'(o_locked), 1);
   endtask

   task automatic wait_model_p1_measure(input string name);
      int t;
      t = 0;
      while (!(m_busy && m_phase == 1 && m_nstr > SETTLE + 2) && t < BOUND) begin
         @(negedge clk);
         t++;
      end
      chk(name, int'(o_phase), 1);
   endtask

   initial begin
      set_rates(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_enable", int'(o_enable), 0);
      chk("rst_phase", int'(o_phase), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_locked", int'(o_locked), 0);
      chk("rst_best_err", int'(o_best_err), 15);
      @(negedge clk); rst = 1'b1;

      for (int k = 1; k <= 24; k++) begin
         @(negedge clk); #1;
         if (k == 4 || k == 8 || k == 12) chk("en_pulse", int'(o_enable), 1);
         if (k == 3 || k == 5) chk("en_gap", int'(o_enable), 0);
         if (k == 5 || k == 21) chk("strobe_on", int'(o_sym_strobe), 1);
         if (k == 9 || k == 13 || k == 17) chk("strobe_off", int'(o_sym_strobe), 0);
         if (k == 24) chk("idle_busy", int'(o_busy), 0);
      end

      // best phase selection
      set_rates(20, 40, 0, 10);
      pulse_start();
      #1;
      chk("start_busy", int'(o_busy), 1);
      wait_lock("best_lock");
      chk("best_phase", int'(o_phase), 2);
      chk("best_err_val", int'(o_best_err), 0);

      // restart from LOCK, tie-break, start mid-MEASURE ignored
      set_rates(0, 0, 0, 0);
      pulse_start();
      #1;
      chk("restart_locked", int'(o_locked), 0);
      chk("restart_busy", int'(o_busy), 1);
      chk("restart_phase", int'(o_phase), 0);
      wait_model_p1_measure("mid_measure_reach");
      pulse_start();
      wait_lock("tie_lock");
      chk("tie_phase", int'(o_phase), 0);
      chk("tie_err", int'(o_best_err), 0);

      // saturation
      set_rates(100, 100, 100, 100);
      pulse_start();
      wait_lock("sat_lock");
      chk("sat_phase", int'(o_phase), 0);
      chk("sat_err", int'(o_best_err), 15);

      // i_start coinciding with the final EVAL is ignored
      set_rates(5, 15, 25, 10);
      pulse_start();
      begin
         int t;
         t = 0;
         while (!(m_busy && m_evalp && m_phase == OS - 1) && t < BOUND) begin
            @(negedge clk);
            t++;
         end
         chk("final_eval_busy", int'(o_busy), 1);
         chk("final_eval_phase", int'(o_phase), 3);
         i_start = 1'b1;
         @(negedge clk); i_start = 1'b0;
         #1;
         chk("eval_start_locked", int'(o_locked), 1);
         chk("eval_start_busy", int'(o_busy), 0);
         repeat (20) @(negedge clk);
      end

      // randomized sweeps
      for (int s = 0; s < 4; s++) begin
         for (int p = 0; p < OS; p++) rate[p] = $urandom_range(0, 30);
         pulse_start();
         wait_lock("rand_lock");
      end

      // reset mid-sweep
      set_rates(10, 10, 10, 10);
      pulse_start();
      wait_model_p1_measure("rst_reach");
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("arst_busy", int'(o_busy), 0);
      chk("arst_locked", int'(o_locked), 0);
      chk("arst_phase", int'(o_phase), 0);
      chk("arst_best_err", int'(o_best_err), 15);
      chk("arst_enable", int'(o_enable), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (200) @(negedge clk);
      #1;
      chk("post_rst_idle", int'(o_busy), 0);
      chk("post_rst_unlocked", int'(o_locked), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
